intersection_controller: RTL and testbench
==========================================

# intersection_controller

Sequences two `traffic_light`-style lamp sets (north–south and east–west) at a single intersection. It guarantees that conflicting greens never overlap, inserts an all-red clearance after every yellow, and optionally serves a latched pedestrian request with a walk phase. It sits between the board clock and the six lamp outputs, replacing free-running per-light sequencing.

## Interface
Parameters:
- `GREEN_CYCLES`, default 8: cycles each green phase lasts. Must be ≥ 1.
- `YELLOW_CYCLES`, default 3: cycles each yellow phase lasts. Must be ≥ 1.
- `ALL_RED_CYCLES`, default 2: cycles of each all-red clearance. Must be ≥ 1.
- `WALK_CYCLES`, default 5: cycles of the pedestrian walk phase. Must be ≥ 1.

Ports:
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Ped_Req` in 1: pedestrian request, sampled every rising edge. Level or pulse; a 1-cycle pulse is sufficient.
- `Ped_Ack` out 1: 1-cycle pulse when the WALK phase is entered.
- `NS_R_LED`, `NS_Y_LED`, `NS_G_LED` out 1 each: north–south lamps, one-hot.
- `EW_R_LED`, `EW_Y_LED`, `EW_G_LED` out 1 each: east–west lamps, one-hot.
- `Walk` out 1: pedestrian walk lamp.

## Operation
- States: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, WALK.
- A direction bit `next_dir` (0 = NS, 1 = EW) selects which green follows ALL_RED or WALK.
- Transitions occur when the phase counter reaches 0:
  - ALL_RED → WALK if a pedestrian request is pending; otherwise → the green selected by `next_dir`.
  - WALK → the green selected by `next_dir`.
  - NS_GREEN → NS_YELLOW → ALL_RED, setting `next_dir` = EW.
  - EW_GREEN → EW_YELLOW → ALL_RED, setting `next_dir` = NS.
- Outputs are a pure decode of the state register:
  - Non-active direction shows red.
  - ALL_RED and WALK: both directions red.
  - `Walk` = 1 only in WALK.
- Pending flag: set by `Ped_Req`, cleared on WALK entry. If both happen in the same cycle, set has priority, so the request is served in a later WALK.
- A request arriving during WALK or a green phase is served at the next ALL_RED exit, not earlier. WALK is never entered except from ALL_RED.
- Phase counter:
  - Width is `$clog2` of the largest parameter, minimum 1 bit.
  - Loaded with `N-1` on entry to a phase of length N, then decrements by 1 per cycle.
  - Never wraps: a transition always reloads it.
- Reset values:
  - State ALL_RED, counter `ALL_RED_CYCLES-1`, `next_dir` = NS, pending = 0.
  - `NS_R_LED` = `EW_R_LED` = 1; all other lamp outputs 0.
  - `Walk` = 0, `Ped_Ack` = 0.
- Reset mid-phase: all outputs return to their reset values immediately, without waiting for a clock edge. Any pending request is discarded.
- Invariant: at most one of `NS_G_LED`/`NS_Y_LED` or `EW_G_LED`/`EW_Y_LED` is non-red at any time. `Walk` = 1 implies both directions are red.

## Timing
- Each phase holds its outputs for exactly N rising edges. Outputs change only on the rising edge that changes state.
- Zero output latency relative to the state register. Outputs are decoded from flops, with no dependency on inputs.
- `Ped_Req` sampled at edge k sets pending, which is visible at edge k+1.
- `Ped_Ack` is high during the first cycle of WALK only.
- After `Reset_n` rises, the first rising edge begins decrementing the ALL_RED counter.
  - With default parameters, `NS_G_LED` rises at the 2nd edge after release.
- Cycle period without pedestrian requests: 2×(GREEN + YELLOW + ALL_RED) = 26 cycles at defaults.

## Configuration
- Macro: `INTERSECTION_PEDESTRIAN_EN`.
- Defined: pending flag, WALK state, `Ped_Ack` and `Walk` behave as described above.
- Not defined:
  - Pending logic and the WALK state are compiled out.
  - `Ped_Req` is ignored.
  - `Walk` and `Ped_Ack` are tied to 0; ports are still present.
  - ALL_RED always exits to the next green.

## Test plan
All scenarios use default parameters.
- **Reset and free run:** hold `Reset_n` = 0 for 3 cycles, then release with no requests. Expect 2 cycles all-red, NS green 8, NS yellow 3, all-red 2, EW green 8, EW yellow 3, all-red 2, then NS green again. Period is 26 cycles.
- **Request during green:** pulse `Ped_Req` for 1 cycle during NS_GREEN cycle 2. Expect NS yellow 3, all-red 2, then `Ped_Ack` pulse and `Walk` = 1 for 5 cycles with all lamps red, followed by EW green.
- **Coincident request on WALK entry:** hold `Ped_Req` high across WALK entry. Expect one `Ped_Ack`; pending stays set; a second WALK follows the next ALL_RED, after EW yellow.
- **Async reset mid-phase:** assert `Reset_n` = 0 mid-EW_GREEN at a non-edge time. Expect outputs to snap immediately to reset values (reds = 1, all else 0) and pending to clear. After release the sequence restarts from ALL_RED.
- **Safety check:** 10,000 cycles with random `Ped_Req`. Assertion: green/yellow never active on both directions simultaneously; `Walk` = 1 only when both directions are red.
- **Macro undefined:** repeat the request-during-green scenario. `Walk`/`Ped_Ack` stay 0 and the timing is identical to free run.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-direction intersection sequencer with all-red clearance after every yellow.
// Optional pedestrian walk phase is enabled by defining INTERSECTION_PEDESTRIAN_EN.
module intersection_controller #(
    parameter int GREEN_CYCLES   = 8,
    parameter int YELLOW_CYCLES  = 3,
    parameter int ALL_RED_CYCLES = 2,
    parameter int WALK_CYCLES    = 5
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Ped_Req,
    output logic Ped_Ack,
    output logic NS_R_LED,
    output logic NS_Y_LED,
    output logic NS_G_LED,
    output logic EW_R_LED,
    output logic EW_Y_LED,
    output logic EW_G_LED,
    output logic Walk
);

    localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int MAX_AW = (ALL_RED_CYCLES > WALK_CYCLES) ? ALL_RED_CYCLES : WALK_CYCLES;
    localparam int MAX_N  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
    localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] L_G  = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] L_Y  = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] L_AR = CW'(ALL_RED_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ALL_RED,
        S_NS_GREEN,
        S_NS_YELLOW,
        S_EW_GREEN,
        S_EW_YELLOW
`ifdef INTERSECTION_PEDESTRIAN_EN
        , S_WALK
`endif
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    state_t        w_green_st;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_dir;
    logic          w_dir_nx;

`ifdef INTERSECTION_PEDESTRIAN_EN
    localparam logic [CW-1:0] L_W = CW'(WALK_CYCLES - 1);
    logic r_pend;
    logic r_ack;
    logic w_walk_go;
`endif

    // r_dir: 0 selects NS green next, 1 selects EW green next
    assign w_green_st = r_dir ? S_EW_GREEN : S_NS_GREEN;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt - 1'b1;
        w_dir_nx   = r_dir;
`ifdef INTERSECTION_PEDESTRIAN_EN
        w_walk_go  = 1'b0;
`endif
        if (r_cnt == '0) begin
            unique case (r_state)
                S_ALL_RED: begin
`ifdef INTERSECTION_PEDESTRIAN_EN
                    if (r_pend) begin
                        w_state_nx = S_WALK;
                        w_cnt_nx   = L_W;
                        w_walk_go  = 1'b1;
                    end else begin
                        w_state_nx = w_green_st;
                        w_cnt_nx   = L_G;
                    end
`else
                    w_state_nx = w_green_st;
                    w_cnt_nx   = L_G;
`endif
                end
                S_NS_GREEN: begin
                    w_state_nx = S_NS_YELLOW;
                    w_cnt_nx   = L_Y;
                end
                S_NS_YELLOW: begin
                    w_state_nx = S_ALL_RED;
                    w_cnt_nx   = L_AR;
                    w_dir_nx   = 1'b1;
                end
                S_EW_GREEN: begin
                    w_state_nx = S_EW_YELLOW;
                    w_cnt_nx   = L_Y;
                end
                S_EW_YELLOW: begin
                    w_state_nx = S_ALL_RED;
                    w_cnt_nx   = L_AR;
                    w_dir_nx   = 1'b0;
                end
`ifdef INTERSECTION_PEDESTRIAN_EN
                S_WALK: begin
                    w_state_nx = w_green_st;
                    w_cnt_nx   = L_G;
                end
`endif
                default: begin
                    w_state_nx = S_ALL_RED;
                    w_cnt_nx   = L_AR;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_ALL_RED;
            r_cnt   <= L_AR;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dir   <= w_dir_nx;
        end
    end

`ifdef INTERSECTION_PEDESTRIAN_EN
    // A request in the same cycle as WALK entry keeps the flag set for a later WALK
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_pend <= Ped_Req | (r_pend & ~w_walk_go);
            r_ack  <= w_walk_go;
        end
    end

    assign Ped_Ack = r_ack;
`else
    logic w_unused_ped;
    assign w_unused_ped = Ped_Req;
    assign Ped_Ack      = 1'b0;
`endif

    always_comb begin
        NS_R_LED = 1'b1;
        NS_Y_LED = 1'b0;
        NS_G_LED = 1'b0;
        EW_R_LED = 1'b1;
        EW_Y_LED = 1'b0;
        EW_G_LED = 1'b0;
        Walk     = 1'b0;
        unique case (r_state)
            S_NS_GREEN: begin
                NS_R_LED = 1'b0;
                NS_G_LED = 1'b1;
            end
            S_NS_YELLOW: begin
                NS_R_LED = 1'b0;
                NS_Y_LED = 1'b1;
            end
            S_EW_GREEN: begin
                EW_R_LED = 1'b0;
                EW_G_LED = 1'b1;
            end
            S_EW_YELLOW: begin
                EW_R_LED = 1'b0;
                EW_Y_LED = 1'b1;
            end
`ifdef INTERSECTION_PEDESTRIAN_EN
            S_WALK: Walk = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller at default parameters.
// Expected lamp sequences follow INTERSECTION_PEDESTRIAN_EN when it is defined.
module tb_intersection_controller;

    logic clk;
    logic rst_n;
    logic ped_req;
    logic ped_ack;
    logic ns_r, ns_y, ns_g;
    logic ew_r, ew_y, ew_g;
    logic walk;

    logic [7:0] w_obs;
    assign w_obs = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_ack};

    // {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G,Walk,Ped_Ack}
    localparam logic [7:0] P_AR  = 8'b100_100_00;
    localparam logic [7:0] P_NSG = 8'b001_100_00;
    localparam logic [7:0] P_NSY = 8'b010_100_00;
    localparam logic [7:0] P_EWG = 8'b100_001_00;
    localparam logic [7:0] P_EWY = 8'b100_010_00;
    localparam logic [7:0] P_WK1 = 8'b100_100_11;
    localparam logic [7:0] P_WK  = 8'b100_100_10;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];

    intersection_controller dut (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .Ped_Req  (ped_req),
        .Ped_Ack  (ped_ack),
        .NS_R_LED (ns_r),
        .NS_Y_LED (ns_y),
        .NS_G_LED (ns_g),
        .EW_R_LED (ew_r),
        .EW_Y_LED (ew_y),
        .EW_G_LED (ew_g),
        .Walk     (walk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic add_phase(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(p);
    endtask

    task automatic add_walk();
`ifdef INTERSECTION_PEDESTRIAN_EN
        exp_q.push_back(P_WK1);
        for (int i = 0; i < 4; i++) exp_q.push_back(P_WK);
`endif
    endtask

    // Releases reset on a falling edge, so the next rising edge is edge 1
    task automatic do_reset();
        ped_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        ped_req = 1'b0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (w_obs !== P_AR) begin
                errors++;
                $display("FAIL reset_hold c=%0d got %b want %b", i, w_obs, P_AR);
            end
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (w_obs !== P_AR) begin
            errors++;
            $display("FAIL reset_release got %b want %b", w_obs, P_AR);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        add_phase(P_AR, 1);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 3);
        add_phase(P_AR, 2);
        add_phase(P_EWG, 8);
        add_phase(P_EWY, 3);
        add_phase(P_AR, 2);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 1);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (w_obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL free_run edge=%0d got %b want %b", k, w_obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_ped_green();
        do_reset();
        add_phase(P_AR, 1);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 3);
        add_phase(P_AR, 2);
        add_walk();
        add_phase(P_EWG, 8);
        add_phase(P_EWY, 3);
        add_phase(P_AR, 2);
        add_phase(P_NSG, 1);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (w_obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL ped_green edge=%0d got %b want %b", k, w_obs, exp_q[k-1]);
            end
            if (k == 3) ped_req = 1'b1;
            if (k == 4) ped_req = 1'b0;
        end
    endtask

    task automatic test_coincident();
        do_reset();
        add_phase(P_AR, 1);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 3);
        add_phase(P_AR, 2);
        add_walk();
        add_phase(P_EWG, 8);
        add_phase(P_EWY, 3);
        add_phase(P_AR, 2);
        add_walk();
        add_phase(P_NSG, 2);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (w_obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL coincident edge=%0d got %b want %b", k, w_obs, exp_q[k-1]);
            end
            if (k == 3) ped_req = 1'b1;
            if (k == 15) ped_req = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        add_phase(P_AR, 1);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 3);
        add_phase(P_AR, 2);
        add_phase(P_EWG, 4);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (w_obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL async_pre edge=%0d got %b want %b", k, w_obs, exp_q[k-1]);
            end
            if (k == 16) ped_req = 1'b1;
            if (k == 17) ped_req = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (w_obs !== P_AR) begin
            errors++;
            $display("FAIL async_snap got %b want %b", w_obs, P_AR);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (w_obs !== P_AR) begin
            errors++;
            $display("FAIL async_hold got %b want %b", w_obs, P_AR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        add_phase(P_AR, 1);
        add_phase(P_NSG, 8);
        add_phase(P_NSY, 3);
        add_phase(P_AR, 2);
        add_phase(P_EWG, 1);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (w_obs !== exp_q[k-1]) begin
                errors++;
                $display("FAIL async_post edge=%0d got %b want %b", k, w_obs, exp_q[k-1]);
            end
        end
    endtask

    task automatic test_safety();
        int  walks;
        logic ok;
        logic ns_act;
        logic ew_act;
        walks = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            ped_req = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            ns_act = ns_y | ns_g;
            ew_act = ew_y | ew_g;
            ok = ((ns_r + ns_y + ns_g) == 2'd1) && ((ew_r + ew_y + ew_g) == 2'd1);
            ok = ok && !(ns_act && ew_act);
            ok = ok && (!walk || (ns_r && ew_r));
            ok = ok && (!ped_ack || walk);
`ifndef INTERSECTION_PEDESTRIAN_EN
            ok = ok && !walk && !ped_ack;
`endif
            if (ped_ack) walks++;
            vectors++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL safety c=%0d got lamps %b want legal", c, w_obs);
            end
        end
        ped_req = 1'b0;
`ifdef INTERSECTION_PEDESTRIAN_EN
        vectors++;
        if (walks == 0) begin
            errors++;
            $display("FAIL safety_walks got %0d want >0", walks);
        end
`else
        vectors++;
        if (walks != 0) begin
            errors++;
            $display("FAIL safety_walks got %0d want 0", walks);
        end
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        ped_req = 1'b0;
        test_reset();
        test_free_run();
        test_ped_green();
        test_coincident();
        test_async_reset();
        test_safety();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
